// File: rtl/step_sequence_controller.sv
// step_sequence_controller: pattern-driven tone sequencer for the piano step
// sequencer. Holds STEPS tone-select words, times each step from a cycle
// count, and plays the pattern for a programmed number of loops
// (0 = until stopped).
// Optional build macro SEQ_GATE_EN: blank Select during the last quarter of
// every step to articulate repeated notes.
module step_sequence_controller #(
  parameter  int STEPS    = 16,
  parameter  int TONES    = 12,
  parameter  int PERIOD_W = 32,
  parameter  int LOOP_W   = 8,
  localparam int IDX_W    = $clog2(STEPS)
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                nStart,
  input  logic                nStop,
  input  logic [PERIOD_W-1:0] Period,
  input  logic [LOOP_W-1:0]   Loops,
  input  logic                WrEn,
  input  logic [IDX_W-1:0]    WrAddr,
  input  logic [TONES-1:0]    WrData,
  output logic [TONES-1:0]    Select,
  output logic                Step,
  output logic [IDX_W-1:0]    StepIdx,
  output logic                Play,
  output logic                Done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic                         nstart_q;
  logic [PERIOD_W-1:0]          period_q, period_d;
  logic [LOOP_W-1:0]            loops_q, loops_d;
  logic [PERIOD_W-1:0]          cnt_q, cnt_d;
  logic [LOOP_W-1:0]            ldone_q, ldone_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [TONES-1:0]             sel_q, sel_d;
  logic                         step_q, step_d;
  logic                         play_q, play_d;
  logic                         done_q, done_d;
  logic [STEPS-1:0][TONES-1:0]  pattern_q;

  logic                         start_req;
  logic [PERIOD_W-1:0]          period_clamp;
  logic                         boundary;
  logic                         last_step;
  logic [LOOP_W-1:0]            ldone_inc;
  logic                         finish;
  logic [IDX_W-1:0]             ld_idx;
  logic [TONES-1:0]             ld_word;

  // Falling edge of the registered start button; a held level never retriggers.
  assign start_req    = nstart_q & ~nStart;
  assign period_clamp = (Period < PERIOD_W'(2)) ? PERIOD_W'(2) : Period;
  assign boundary     = (cnt_q == '0);
  assign last_step    = (idx_q == IDX_W'(STEPS - 1));
  assign ldone_inc    = ldone_q + LOOP_W'(1);
  assign finish       = last_step && (loops_q != '0) && (ldone_inc == loops_q);

  // Word loaded at a step boundary; a same-cycle write to that slot wins.
  assign ld_idx  = (state_q == S_PLAY) ? idx_q + IDX_W'(1) : '0;
  assign ld_word = (WrEn && (WrAddr == ld_idx)) ? WrData : pattern_q[ld_idx];

  // State register.
  always_ff @(posedge Clock) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; stop always wins over a coincident boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_req && nStop) state_d = S_PLAY;
      S_PLAY: begin
        if (!nStop)                  state_d = S_IDLE;
        else if (boundary && finish) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values, registered below.
  always_comb begin
    period_d = period_q;
    loops_d  = loops_q;
    cnt_d    = cnt_q;
    ldone_d  = ldone_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    step_d   = 1'b0;
    play_d   = play_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        play_d = 1'b0;
        sel_d  = '0;
        idx_d  = '0;
        if (start_req && nStop) begin
          period_d = period_clamp;
          loops_d  = Loops;
          cnt_d    = period_clamp - PERIOD_W'(1);
          ldone_d  = '0;
          sel_d    = ld_word;
          step_d   = 1'b1;
          play_d   = 1'b1;
        end
      end
      S_PLAY: begin
        if (!nStop) begin
          play_d = 1'b0;
          sel_d  = '0;
          idx_d  = '0;
          cnt_d  = '0;
        end else if (boundary) begin
          if (last_step) ldone_d = ldone_inc;
          if (finish) begin
            done_d = 1'b1;
            play_d = 1'b0;
            sel_d  = '0;
            idx_d  = '0;
            cnt_d  = '0;
          end else begin
            idx_d  = ld_idx;
            sel_d  = ld_word;
            step_d = 1'b1;
            cnt_d  = period_q - PERIOD_W'(1);
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: begin
        play_d = 1'b0;
        sel_d  = '0;
        idx_d  = '0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      nstart_q <= 1'b1;
      period_q <= '0;
      loops_q  <= '0;
      cnt_q    <= '0;
      ldone_q  <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      step_q   <= 1'b0;
      play_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      nstart_q <= nStart;
      period_q <= period_d;
      loops_q  <= loops_d;
      cnt_q    <= cnt_d;
      ldone_q  <= ldone_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      step_q   <= step_d;
      play_q   <= play_d;
      done_q   <= done_d;
    end
  end

  // Pattern store, one write-enabled word per step.
  for (genvar s = 0; s < STEPS; s++) begin : g_pat
    always_ff @(posedge Clock) begin
      if (!nReset)                              pattern_q[s] <= '0;
      else if (WrEn && (WrAddr == IDX_W'(s)))   pattern_q[s] <= WrData;
    end
  end

`ifdef SEQ_GATE_EN
  assign Select = (cnt_q < (period_q >> 2)) ? '0 : sel_q;
`else
  assign Select = sel_q;
`endif
  assign Step    = step_q;
  assign StepIdx = idx_q;
  assign Play    = play_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_step_sequence_controller.sv
// Directed bench for step_sequence_controller with a 4-step pattern.
module tb_step_sequence_controller;
  localparam int STEPS = 4;
  localparam int TONES = 12;

  logic              Clock = 1'b0;
  logic              nReset = 1'b0;
  logic              nStart = 1'b1;
  logic              nStop = 1'b1;
  logic [31:0]       Period = '0;
  logic [7:0]        Loops = '0;
  logic              WrEn = 1'b0;
  logic [1:0]        WrAddr = '0;
  logic [TONES-1:0]  WrData = '0;
  logic [TONES-1:0]  Select;
  logic              Step;
  logic [1:0]        StepIdx;
  logic              Play;
  logic              Done;

  logic [TONES-1:0]  pm [STEPS];
  int                n_chk = 0;
  int                n_bad = 0;

  step_sequence_controller #(.STEPS(STEPS), .TONES(TONES), .PERIOD_W(32), .LOOP_W(8)) dut (
    .Clock(Clock), .nReset(nReset), .nStart(nStart), .nStop(nStop),
    .Period(Period), .Loops(Loops), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Select(Select), .Step(Step), .StepIdx(StepIdx), .Play(Play), .Done(Done)
  );

  always #10 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  // Expected Select for position p inside a step of length per.
  function automatic logic [TONES-1:0] exp_sel(input logic [TONES-1:0] w, input int p, input int per);
`ifdef SEQ_GATE_EN
    if ((per - 1 - p) < (per >> 2)) return '0;
`endif
    return w;
  endfunction

  task automatic wr(input int a, input logic [TONES-1:0] d);
    WrEn = 1'b1; WrAddr = 2'(a); WrData = d;
    tick();
    WrEn = 1'b0;
    pm[a] = d;
  endtask

  // Leaves the bench observing cycle 0 of the new run.
  task automatic start_run(input int per, input int lp);
    Period = 32'(per); Loops = 8'(lp);
    nStart = 1'b1;
    tick();
    nStart = 1'b0;
    tick();
  endtask

  // Check cycles n0..n1-1 of a run, advancing one clock after each.
  task automatic chk_run(input int n0, input int n1, input int per);
    for (int c = n0; c < n1; c++) begin
      int p, ix;
      p  = c % per;
      ix = (c / per) % STEPS;
      chk($sformatf("play c%0d", c), 32'(Play), 32'd1);
      chk($sformatf("step c%0d", c), 32'(Step), (p == 0) ? 32'd1 : 32'd0);
      chk($sformatf("idx c%0d", c), 32'(StepIdx), 32'(ix));
      chk($sformatf("sel c%0d", c), 32'(Select), 32'(exp_sel(pm[ix], p, per)));
      chk($sformatf("done c%0d", c), 32'(Done), 32'd0);
      tick();
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, " play"}, 32'(Play), 32'd0);
    chk({tag, " sel"}, 32'(Select), 32'd0);
    chk({tag, " idx"}, 32'(StepIdx), 32'd0);
    chk({tag, " step"}, 32'(Step), 32'd0);
    chk({tag, " done"}, 32'(Done), 32'(exp_done));
  endtask

  initial begin
    for (int i = 0; i < STEPS; i++) pm[i] = '0;

    // Reset state
    tick(); tick();
    chk_idle("rst", 1'b0);
    nReset = 1'b1;
    tick();
    chk_idle("post_rst", 1'b0);

    for (int i = 0; i < STEPS; i++) wr(i, 12'(1 << i));

    // Natural completion, two loops, nStart then held low
    start_run(4, 2);
    chk_run(0, 32, 4);
    chk_idle("nat done", 1'b1);
    tick();
    chk_idle("nat idle", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("held_low", 1'b0);
    end

    // Second falling edge during PLAY is ignored
    start_run(2, 1);
    chk_run(0, 2, 2);
    nStart = 1'b1;
    chk_run(2, 3, 2);
    nStart = 1'b0;
    chk_run(3, 8, 2);
    chk_idle("edge2 done", 1'b1);
    tick();
    chk_idle("edge2 idle", 1'b0);
    tick();
    chk_idle("edge2 idle2", 1'b0);

    // nStop low in IDLE blocks a start; edge is consumed
    nStart = 1'b1;
    tick();
    nStop = 1'b0; nStart = 1'b0;
    tick();
    chk_idle("stop_blk", 1'b0);
    nStop = 1'b1;
    tick();
    chk_idle("stop_blk2", 1'b0);

    // Period clamp to 2, infinite loops, then abort
    start_run(0, 0);
    chk_run(0, 24, 2);
    nStop = 1'b0;
    tick();
    chk_idle("abort", 1'b0);
    nStop = 1'b1;
    tick();
    chk_idle("abort2", 1'b0);

    // Write-first on boundary, and mid-step write deferred
    start_run(4, 0);
    chk_run(0, 3, 4);
    WrEn = 1'b1; WrAddr = 2'd1; WrData = 12'h800;
    chk_run(3, 4, 4);
    WrEn = 1'b0;
    pm[1] = 12'h800;
    chk_run(4, 13, 4);
    WrEn = 1'b1; WrAddr = 2'd3; WrData = 12'h400;
    chk_run(13, 14, 4);
    WrEn = 1'b0;
    chk_run(14, 16, 4);
    pm[3] = 12'h400;
    chk_run(16, 32, 4);
    nStop = 1'b0;
    tick();
    chk_idle("wf stop", 1'b0);
    nStop = 1'b1;

    // Reset during step 2; pattern clears, no Done
    start_run(4, 0);
    chk_run(0, 9, 4);
    nStart = 1'b1;
    nReset = 1'b0;
    tick();
    chk_idle("mid_rst", 1'b0);
    nReset = 1'b1;
    tick();
    chk_idle("mid_rst2", 1'b0);
    for (int i = 0; i < STEPS; i++) pm[i] = '0;
    start_run(4, 1);
    chk_run(0, 16, 4);
    chk_idle("clr done", 1'b1);
    tick();

    // Period 8 with a single word (articulation visible when gated)
    wr(0, 12'h010);
    start_run(8, 1);
    chk_run(0, 32, 8);
    chk_idle("p8 done", 1'b1);
    tick();
    chk_idle("p8 idle", 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/step_sequence_controller.md
Name: step_sequence_controller

Overview:
- Sequences the tone datapath for the piano step sequencer.
- Holds a programmable pattern of STEPS tone-select words and generates the step timing internally from a cycle-count period.
- Drives the tone Select bus and Play for a programmed number of loops, replacing the separate BPM-counter/loop-counter pairing with one controller.
- Select feeds audio_generator. Play gates the sample registers in front of the audio codec.

Parameters:
- STEPS, 16, number of pattern steps; power of two, ≥2.
- TONES, 12, width of one tone-select word (one-hot or multi-hot tone bits).
- PERIOD_W, 32, width of the step period in Clock cycles.
- LOOP_W, 8, width of the loop count.

Ports:
- Clock  in  1  system clock (50 MHz)
- nReset  in  1  synchronous active-low reset
- nStart  in  1  active-low start request (push-button level)
- nStop  in  1  active-low abort, level-sensitive
- Period  in  PERIOD_W  Clock cycles per step; values <2 are treated as 2
- Loops  in  LOOP_W  passes through the pattern; 0 = loop until stopped
- WrEn  in  1  pattern write strobe
- WrAddr  in  log2(STEPS)  pattern write index
- WrData  in  TONES  pattern write data
- Select  out  TONES  current tone select
- Step  out  1  one-cycle pulse at each step boundary
- StepIdx  out  log2(STEPS)  index of the step being played
- Play  out  1  playback active
- Done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset (nReset=0 at a Clock edge):
  - State goes to IDLE.
  - All pattern entries, Select, StepIdx, Step, Play, Done, the step counter and the loop counter clear to 0.
  - The nStart edge-detect register is set to 1.
- Start detection:
  - A start request is a registered 1→0 transition of nStart.
  - A request is honoured only in IDLE. It is ignored in PLAY and DONE.
- States are IDLE, PLAY and DONE.
- IDLE → PLAY, on a start request with nStop=1:
  - Latch Period (clamped to ≥2) and Loops.
  - Next cycle: Play=1, StepIdx=0, Select=pattern[0], Step=1, step counter = latched Period−1, loops-done counter = 0.
- PLAY, step timing:
  - The step counter decrements each cycle.
  - When the counter is 0, the next cycle is a boundary: StepIdx+1 (wraps STEPS−1→0), Select=pattern[new idx], Step=1, counter reloads to Period−1.
  - Steps are therefore exactly Period cycles apart.
- PLAY, loop accounting:
  - On wrap to 0 the loops-done counter increments.
  - If Loops≠0 and the incremented count equals Loops, go to DONE instead of wrapping. No Step pulse is issued for that boundary.
  - Loops=0 never reaches DONE.
- DONE:
  - Lasts one cycle: Done=1, Play=0, Select=0, StepIdx=0.
  - Then IDLE.
- nStop=0 in PLAY:
  - Next cycle goes to IDLE with Play=0, Select=0 and StepIdx=0.
  - No Done pulse. It overrides a coincident boundary.
- nStop=0 in IDLE blocks a start request.
- Pattern writes:
  - Accepted in any state except reset.
  - A write during PLAY takes effect the next time that step is loaded. Select is not updated mid-step.
  - If a write hits the address being loaded on the same boundary cycle, the new WrData is forwarded to Select (write-first).
- Period and Loops changes during PLAY have no effect until the next start.
- Step, Done and Play are registered outputs.

Optional Feature:
- Macro: SEQ_GATE_EN.
- When defined, each step is articulated: Select is forced to 0 while the step counter is less than latched Period>>2, i.e. during the last quarter of every step. Step, StepIdx and Play are unaffected.
- When undefined, Select holds pattern[StepIdx] for the full step.

Test Plan:
- Reset mid-playback:
  - Stimulus: start with Period=4, then nReset=0 for one cycle during step 2.
  - Response: all outputs 0 next cycle; pattern reads back 0 on a subsequent run; no Done pulse.
- Natural completion:
  - Stimulus: STEPS=4, pattern={0x001,0x002,0x004,0x008}, Period=4, Loops=2, nStart falling edge.
  - Response: Step pulses every 4 cycles; Select sequence 001,002,004,008,001,002,004,008; Play high for 32 cycles; Done=1 exactly once in the cycle after the last step expires; then IDLE.
- Period clamp and infinite loop:
  - Stimulus: Period=0, Loops=0.
  - Response: Step every 2 cycles with StepIdx wrapping 3→0 indefinitely; nStop=0 then gives Play=0 and Select=0 next cycle with Done=0.
- Write-first forwarding:
  - Stimulus: during PLAY, WrEn with WrAddr=1, WrData=0x800 on the exact boundary cycle entering step 1.
  - Response: Select=0x800 for step 1.
  - Stimulus: a write to step 3 while step 3 is playing.
  - Response: Select for step 3 unchanged until the next loop.
- Start-request rules:
  - Stimulus: nStart held low across a run, and a second falling edge during PLAY.
  - Response: only one run occurs; the held level does not retrigger after Done; restart requires nStart to return to 1 then 0.
- With SEQ_GATE_EN defined:
  - Stimulus: Period=8, pattern[0]=0x010.
  - Response: Select=0x010 for 6 cycles then 0 for 2 cycles within each step.
